mult_iter_param: RTL and testbench

MULT_ITER_PARAM -- requirements
Module: mult_iter_param

---
 rtl/mult_iter_param.sv | 113 +++++++++++
 tb/tb_mult_iter_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mult_iter_param.sv
// Iterative shift-add multiplier with per-operand signed/unsigned mode (IDLE -> RUN -> FIX).
// Define MULT_ITER_EARLY_TERM_EN to end RUN once the remaining multiplier bits are all zero.
module mult_iter_param #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 a_signed,
    input  logic                 b_signed,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product_out
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 done_q, done_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 last_bit;

    // Magnitudes are WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1) exactly.
    assign a_neg = a_signed & op_a[WIDTH-1];
    assign b_neg = b_signed & op_b[WIDTH-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

`ifdef MULT_ITER_EARLY_TERM_EN
    assign last_bit = (cnt_q == CW'(WIDTH-1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_bit = (cnt_q == CW'(WIDTH-1));
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = a_neg ^ b_neg;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                prod_d  = neg_q ? -acc_q : acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign product_out = prod_q;

endmodule

// File: tb/tb_mult_iter_param.sv
// Scoreboard bench for mult_iter_param at WIDTH=32 and WIDTH=8; honours MULT_ITER_EARLY_TERM_EN.
module tb_mult_iter_param;

    typedef struct {
        logic [63:0] prod;
        int unsigned cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic        start32 = 1'b0, as32 = 1'b0, bs32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] p32;

    logic        start8 = 1'b0, as8 = 1'b0, bs8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    exp_t q32[$];
    exp_t q8[$];

    mult_iter_param #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .a_signed(as32), .b_signed(bs32),
        .op_a(a32), .op_b(b32), .busy(busy32), .done(done32), .product_out(p32)
    );

    mult_iter_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a_signed(as8), .b_signed(bs8),
        .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .product_out(p8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Edges from start to done: k+2 with early exit on the bit length k of |B|, else WIDTH+2.
    function automatic int unsigned lat(int unsigned w, logic [63:0] b, logic bs);
        logic [63:0] m;
        int unsigned k;
        m = b;
        if (bs && b[w-1]) m = (~b + 64'd1) & ((64'd1 << w) - 64'd1);
        k = 1;
        for (int unsigned i = 0; i < w; i++) if (m[i]) k = i + 1;
`ifdef MULT_ITER_EARLY_TERM_EN
        return k + 2;
`else
        return w + 2;
`endif
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Called at a negedge; the start edge is the next posedge.
    task automatic issue32(string name, logic [31:0] a, logic [31:0] b, logic as, logic bs,
                           logic [63:0] prod);
        exp_t e;
        a32 = a; b32 = b; as32 = as; bs32 = bs; start32 = 1'b1;
        e.prod = prod; e.cyc = cyc + lat(32, {32'd0, b}, bs); e.name = name;
        q32.push_back(e);
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic issue8(string name, logic [7:0] a, logic [7:0] b, logic as, logic bs,
                          logic [15:0] prod);
        exp_t e;
        a8 = a; b8 = b; as8 = as; bs8 = bs; start8 = 1'b1;
        e.prod = {48'd0, prod}; e.cyc = cyc + lat(8, {56'd0, b}, bs); e.name = name;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q32.size() != 0 || q8.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: pending %0d/%0d expected 0/0", q32.size(), q8.size());
            q32.delete();
            q8.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done32) begin
            if (q32.size() == 0) begin
                check("done32_unexpected", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                check({e.name, "_prod"}, p32, e.prod);
                check({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                check("done8_unexpected", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                check({e.name, "_prod"}, {48'd0, p8}, e.prod);
                check({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        int unsigned n;
        repeat (2) @(negedge clk);
        check("rst_busy32", {63'd0, busy32}, 64'd0);
        check("rst_done32", {63'd0, done32}, 64'd0);
        check("rst_prod32", p32, 64'd0);
        check("rst_prod8", {48'd0, p8}, 64'd0);
        reset = 1'b0;

        issue32("u_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001);
        issue8("s8_80x7f", 8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080);
        drain();
        issue32("s_min_sq", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000);
        issue8("u8_ffxff", 8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01);
        drain();
        issue32("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000080000000);
        issue8("s8_min_sq", 8'h80, 8'h80, 1'b1, 1'b1, 16'h4000);
        drain();
        issue32("su_m1xmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF00000001);
        issue8("us8_255xm1", 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFF01);
        drain();
        issue32("us_3xm2", 32'h00000003, 32'hFFFFFFFE, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFA);
        drain();
        issue32("b_zero", 32'h12345678, 32'h00000000, 1'b0, 1'b0, 64'h0);
        drain();

        // Back-to-back: second start lands in the done cycle of the first.
        issue32("bb_first", 32'h00000007, 32'hFFFFFFFD, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFEB);
        n = 0;
        while (!done32 && n < 100) begin @(negedge clk); n++; end
        issue32("bb_second", 32'h80000000, 32'h00000002, 1'b0, 1'b0, 64'h0000000100000000);
        drain();

        // Start and operand change while busy must not disturb 10*20.
        issue32("u_10x20", 32'd10, 32'd20, 1'b0, 1'b0, 64'd200);
        repeat (3) @(negedge clk);
        check("busy_mid_run", {63'd0, busy32}, 64'd1);
        a32 = 32'd99; b32 = 32'd99; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        drain();

        // Reset at edge 12 of a long operation, with start held during reset.
        issue32("aborted", 32'h00000003, 32'h80000001, 1'b0, 1'b0, 64'h0);
        repeat (10) @(negedge clk);
        reset = 1'b1; start32 = 1'b1; start8 = 1'b1;
        q32.delete();
        @(negedge clk);
        check("midrst_busy", {63'd0, busy32}, 64'd0);
        check("midrst_done", {63'd0, done32}, 64'd0);
        check("midrst_prod", p32, 64'd0);
        check("midrst_busy8", {63'd0, busy8}, 64'd0);
        reset = 1'b0; start8 = 1'b0;
        issue32("post_rst", 32'h0000000B, 32'h0000000D, 1'b0, 1'b0, 64'd143);
        drain();

        repeat (3) @(negedge clk);
        check("idle_busy", {63'd0, busy32}, 64'd0);
        check("idle_busy8", {63'd0, busy8}, 64'd0);
        check("hold_prod", p32, 64'd143);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
